// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding
// and small decode helpers used by the unit and its bench.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-side handshake and HI/LO access bundle for muldiv_unit.
interface muldiv_unit_if #(parameter int unsigned WIDTH = 32) ();
  import muldiv_unit_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. acc holds {upper, lower} = {hi, lo} of the working value.
module muldiv_unit_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [WIDTH-1:0]   operand,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    addend = acc[0] ? operand : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, operand};
    if (is_div) begin
      // Borrow out of the W+1-bit subtract means the divisor did not fit.
      if (diff[WIDTH]) acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// WIDTH run steps plus one sign-fix cycle; done pulses as HI/LO commit.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   operand, hi_r, lo_r, res_hi, res_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic               is_div, neg_q, neg_r, done_r;

  muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .operand  (operand),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_comb begin
    sign_a = op_is_signed(bus.op) & bus.a[WIDTH-1];
    sign_b = op_is_signed(bus.op) & bus.b[WIDTH-1];
    mag_a  = sign_a ? -bus.a : bus.a;
    mag_b  = sign_b ? -bus.b : bus.b;
    // neg_q is the product sign for multiplies, the quotient sign for divides.
    prod   = neg_q ? -acc : acc;
    res_hi = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                    : prod[2*WIDTH-1:WIDTH];
    res_lo = is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                    : prod[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= (state == FIX) && !bus.flush;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (bus.start && !bus.flush) begin
            is_div <= op_is_div(bus.op);
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            count  <= CW'(WIDTH - 1);
            if (op_is_div(bus.op)) begin
              acc     <= {{WIDTH{1'b0}}, mag_a};
              operand <= mag_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, mag_b};
              operand <= mag_a;
            end
          end
        end
        RUN: begin
          if (!bus.flush) begin
            acc <= acc_next;
            if (count != '0) count <= count - CW'(1);
          end
        end
        FIX: begin
          if (!bus.flush) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO values and latencies.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic resetn;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          left;
  logic [31:0] m_hi, m_lo;
  logic        m_done;
  logic [63:0] pend;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] model_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULTU: r = {32'd0, a} * {32'd0, b};
      MD_MULT:  r = 64'(sa * sb);
      MD_DIVU:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) r = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        else            r = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: a launched op keeps the unit busy for 33 cycles, then commits.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      left   <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (left == 0) begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
        if (bus.start && !bus.flush) begin
          pend <= model_op(bus.op, bus.a, bus.b);
          left <= 33;
        end
      end else if (bus.flush) begin
        left <= 0;
      end else begin
        left <= left - 1;
        if (left == 1) begin
          m_hi   <= pend[63:32];
          m_lo   <= pend[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("cyc_busy", 32'(bus.busy), 32'(left != 0));
      check("cyc_done", 32'(bus.done), 32'(m_done));
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic wait_done(input string name, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    wait_done(name, cyc);
    check({name, "_latency"}, 32'(cyc), 32'd34);
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int cyc;
    int dones;
    bus.start = 1'b0;
    bus.op    = MD_MULTU;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    resetn    = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    run_op("divu_100_7",   MD_DIVU,  32'd100,        32'd7,          32'd2,          32'd14);
    run_op("div_m7_2",     MD_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD);
    run_op("div_ovf",      MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);
    run_op("mult_m1_2",    MD_MULT,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE);
    run_op("multu_max_2",  MD_MULTU, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE);
    run_op("mult_min_min", MD_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0);
    run_op("divu_5_0",     MD_DIVU,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF);
    run_op("div_m5_0",     MD_DIV,   32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'd1);
    run_op("div_100_m7",   MD_DIV,   32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2);

    // Flush mid-run: busy drops next cycle, no commit, no done.
    bus.op = MD_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) begin
        check("flush_busy", 32'(bus.busy), 32'd0);
        bus.flush = 1'b0;
      end
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_hi_kept", bus.hi, 32'd2);
    check("flush_lo_kept", bus.lo, 32'hFFFF_FFF2);

    // Start and flush together launch nothing.
    bus.op = MD_MULTU; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("startflush_busy", 32'(bus.busy), 32'd0);
    dones = 0;
    repeat (36) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("startflush_no_done", 32'(dones), 32'd0);
    check("startflush_lo_kept", bus.lo, 32'hFFFF_FFF2);

    // Direct HI write while busy is dropped.
    bus.op = MD_MULTU; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("busy_write_hi", bus.hi, 32'd2);
    wait_done("multu_3_5", cyc);
    check("multu_3_5_hi", bus.hi, 32'd0);
    check("multu_3_5_lo", bus.lo, 32'd15);

    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("idle_write_hi", bus.hi, 32'h1234);
    check("idle_write_lo", bus.lo, 32'd15);

    // Direct LO write alongside start lands now; the result overwrites later.
    bus.op = MD_MULTU; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.start = 1'b0; bus.lo_we = 1'b0;
    check("startwrite_lo", bus.lo, 32'hABCD);
    check("startwrite_hi", bus.hi, 32'h1234);
    wait_done("multu_6_7", cyc);
    check("multu_6_7_hi", bus.hi, 32'd0);
    check("multu_6_7_lo", bus.lo, 32'd42);

    // Asynchronous reset in the middle of a run.
    bus.op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    bus.hi_we = 1'b1; bus.wdata = 32'h5555;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("prereset_hi", bus.hi, 32'h5555);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_hi", bus.hi, 32'd0);
    check("midreset_lo", bus.lo, 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    run_op("multu_7_6", MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
